uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding for uart_tx / uart_rx.
package uart_pkg;

  localparam int unsigned CLK_FREQ = 12_000_000;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned DIVISOR  = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = DIVISOR / 2;

  localparam int unsigned CNT_W    = 13;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic start_edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops reset to the idle-high line level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_sync_o    = sync_q;
  assign start_edge_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit glitch rejection, mid-bit sampling, stop-bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int unsigned BAUD     = uart_pkg::BAUD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_in,
  output logic [DATA_W-1:0]   rx_data,
  output logic                rx_valid,
  output logic                frame_err,
  output logic                rx_busy
);

  localparam int unsigned BIT_CLKS  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);

  logic rx_sync;
  logic start_edge;

  uart_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]        shift_q, shift_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;

  uart_rx_sync u_sync (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx_in),
    .rx_sync_o    (rx_sync),
    .start_edge_o (start_edge)
  );

  // State and datapath registers; reset mid-frame drops the partial byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: bit timing counts from START_BIT entry; STOP exits at mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Edge-triggered only: a line held low (break) cannot restart reception.
        if (start_edge) begin
          state_d = START_BIT;
        end
      end

      START_BIT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // Line back high at the start-bit centre means it was a glitch.
          state_d = rx_sync ? IDLE : DATA_BITS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA_BITS: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = STOP_BIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP_BIT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx, run at a reduced bit period (40 clocks/bit).
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 4_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned D        = CLK_FREQ / BAUD;   // 40
  localparam int unsigned HALF     = D / 2;             // 20
  localparam int unsigned LATENCY  = 3 + HALF + 9 * D;  // rx_in fall to rx_valid
  localparam int unsigned BREAK_CLKS = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          valid_cnt = 0;
  int          ferr_cnt = 0;
  int unsigned cyc = 0;
  int unsigned tx_start_cyc = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned prev_valid_cyc = 0;
  logic [7:0]  last_good = 8'h00;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every pulse pops one expectation from the scoreboard.
  always @(negedge clk) begin
    if (!reset && (rx_valid || frame_err)) begin
      checks++;
      if (rx_valid && frame_err) begin
        errors++;
        $display("FAIL pulse_exclusive: rx_valid=%b frame_err=%b both high at cyc %0d", rx_valid, frame_err, cyc);
      end
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: rx_valid=%b frame_err=%b data=%h with empty scoreboard", rx_valid, frame_err, rx_data);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (frame_err !== mon_e.is_err) begin
          errors++;
          $display("FAIL pulse_kind: frame_err=%b expected %b", frame_err, mon_e.is_err);
        end
        checks++;
        if (rx_data !== mon_e.data) begin
          errors++;
          $display("FAIL rx_data: got %h expected %h", rx_data, mon_e.data);
        end
      end
      if (rx_valid) begin
        valid_cnt++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      if (frame_err) ferr_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (D) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_val);
    exp_t e;
    if (stop_val) begin
      e.is_err  = 1'b0;
      e.data    = b;
      last_good = b;
    end else begin
      e.is_err  = 1'b1;
      e.data    = last_good;
    end
    sb.push_back(e);
    tx_start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_val);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs still pending after %0d cycles", sb.size(), max_cyc);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_loopback();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    wait_drain(4 * D);
    repeat (D) @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL loop_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++;
    if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL loop_frame_err: got %0d expected 0", ferr_cnt - f0); end
    checks++;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL loop_rx_data: got %h expected a5", rx_data); end
    checks++;
    if (last_valid_cyc - tx_start_cyc !== LATENCY) begin
      errors++;
      $display("FAIL loop_latency: got %0d expected %0d", last_valid_cyc - tx_start_cyc, LATENCY);
    end
  endtask

  task automatic test_boundary();
    int v0 = valid_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain(4 * D);
    repeat (D) @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL bound_valid_count: got %0d expected 2", valid_cnt - v0); end
    checks++;
    if (rx_data !== 8'hFF) begin errors++; $display("FAIL bound_rx_data: got %h expected ff", rx_data); end
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    rx_in = 1'b0;
    repeat (10) @(negedge clk);
    rx_in = 1'b1;
    repeat (HALF + 2 - 10) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_before: got %b expected 1", rx_busy); end
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b expected 0", rx_busy); end
    repeat (3 * D) @(negedge clk);
    checks++;
    if ((valid_cnt - v0) + (ferr_cnt - f0) !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: got %0d valid %0d ferr expected 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_err();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    int busy_seen = 0;
    logic [7:0] held = last_good;
    send_frame(8'h3C, 1'b0);
    repeat (BREAK_CLKS) begin
      @(negedge clk);
      if (rx_busy) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin errors++; $display("FAIL break_retrigger: busy for %0d cycles expected 0", busy_seen); end
    rx_in = 1'b1;
    repeat (3 * D) @(negedge clk);
    wait_drain(D);
    checks++;
    if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
    checks++;
    if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_valid_count: got %0d expected 0", valid_cnt - v0); end
    checks++;
    if (rx_data !== held) begin errors++; $display("FAIL ferr_rx_data_held: got %h expected %h", rx_data, held); end
  endtask

  task automatic test_reset_mid();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    logic [7:0] b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx_in = b[4];
    repeat (D / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", rx_busy); end
    rx_in = 1'b1;
    repeat (2 * D) @(negedge clk);
    checks++;
    if ((valid_cnt - v0) + (ferr_cnt - f0) !== 0) begin
      errors++;
      $display("FAIL midreset_pulses: got %0d valid %0d ferr expected 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
    send_frame(8'h81, 1'b1);
    wait_drain(4 * D);
    checks++;
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midreset_valid_count: got %0d expected 1", valid_cnt - v0); end
    checks++;
    if (rx_data !== 8'h81) begin errors++; $display("FAIL midreset_rx_data: got %h expected 81", rx_data); end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    wait_drain(4 * D);
    repeat (D) @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); end
    checks++;
    if (last_valid_cyc - prev_valid_cyc !== 10 * D) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d expected %0d", last_valid_cyc - prev_valid_cyc, 10 * D);
    end
    checks++;
    if (rx_data !== 8'hAA) begin errors++; $display("FAIL b2b_rx_data: got %h expected aa", rx_data); end
  endtask

  initial begin
    reset = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_boundary();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    repeat (2 * D) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_empty: %0d entries left expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
